antilog_shift_out: RTL and testbench

ANTILOG_SHIFT_OUT -- requirements
Module: antilog_shift_out

---
 rtl/antilog_shift_out.sv | 114 +++++++++++
 tb/tb_antilog_shift_out.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/antilog_shift_out.sv
// rtl/antilog_shift_out.sv - two-stage antilog reconstruction: mantissa barrel shift with saturation
// Stage 1 registers operands and decodes the shift; stage 2 shifts, saturates and holds the result.
module antilog_shift_out #(
  parameter int DWIDTH  = 16,
  parameter int M_WIDTH = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [$clog2(DWIDTH):0]    in_final_k,
  input  logic [2*DWIDTH-1:0]        in_mantissa,
  input  logic                       in_zero,
  input  logic                       in_sign,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*DWIDTH-1:0]        out_product,
  output logic                       out_sign,
  output logic                       out_ovf,
  output logic                       ovf_sticky,
  input  logic                       ovf_clr
);
  localparam int PW = 2 * DWIDTH;
  localparam int KW = $clog2(DWIDTH) + 1;

  logic              s1_valid_q, s2_valid_q;
  logic              s1_adv, s2_adv;
  logic              s1_zero_q, s1_sign_q, s1_left_q, s1_sat_q;
  logic [M_WIDTH:0]  s1_mant_q;
  logic [KW-1:0]     s1_amt_q;
  logic [PW-1:0]     s2_prod_q;
  logic              s2_sign_q, s2_ovf_q;
  logic              sticky_q, sticky_d;

  logic [31:0]       k_ext;
  logic              left_d, sat_d;
  logic [KW-1:0]     amt_d;
  logic [PW-1:0]     mant_ext, prod_d;
  logic              sign_d, ovf_d;
  logic              unused_mant_hi;

  assign unused_mant_hi = ^in_mantissa[PW-1:M_WIDTH+1];

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // The result saturates once its leading bit would reach the top product bit.
  always_comb begin
    k_ext  = 32'(in_final_k);
    left_d = (k_ext >= 32'(M_WIDTH));
    amt_d  = left_d ? KW'(k_ext - 32'(M_WIDTH)) : KW'(32'(M_WIDTH) - k_ext);
    sat_d  = ((k_ext + 32'd1) >= 32'(PW));
  end

  always_comb begin
    mant_ext = PW'(s1_mant_q);
    prod_d   = s1_left_q ? (mant_ext << s1_amt_q) : (mant_ext >> s1_amt_q);
    sign_d   = s1_sign_q;
    ovf_d    = 1'b0;
    if (s1_zero_q) begin
      prod_d = '0;
      sign_d = 1'b0;
    end else if (s1_sat_q) begin
      prod_d = '1;
      ovf_d  = 1'b1;
    end
  end

  always_comb begin
    sticky_d = sticky_q;
    if (out_valid && out_ready && out_ovf) begin
      sticky_d = 1'b1;
    end else if (ovf_clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      if (s1_adv) s1_valid_q <= in_valid;
      if (s2_adv) s2_valid_q <= s1_valid_q;
      sticky_q <= sticky_d;
    end
  end

  // Payload registers follow their stage enables; validity alone is reset.
  always_ff @(posedge clk) begin
    if (s1_adv) begin
      s1_zero_q <= in_zero;
      s1_sign_q <= in_sign;
      s1_mant_q <= in_mantissa[M_WIDTH:0];
      s1_left_q <= left_d;
      s1_amt_q  <= amt_d;
      s1_sat_q  <= sat_d;
    end
    if (s2_adv) begin
      s2_prod_q <= prod_d;
      s2_sign_q <= sign_d;
      s2_ovf_q  <= ovf_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_product = s2_valid_q ? s2_prod_q : '0;
  assign out_sign    = s2_valid_q & s2_sign_q;
  assign out_ovf     = s2_valid_q & s2_ovf_q;
  assign ovf_sticky  = sticky_q;

endmodule

// File: tb/tb_antilog_shift_out.sv
// tb/tb_antilog_shift_out.sv - directed and random checks of antilog_shift_out against an arithmetic model
module tb_antilog_shift_out;
  localparam int DW = 8;
  localparam int MW = 6;
  localparam int PW = 2 * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_zero, in_sign;
  logic [3:0]    in_final_k;
  logic [PW-1:0] in_mantissa;
  logic          out_valid, out_ready, out_sign, out_ovf, ovf_sticky, ovf_clr;
  logic [PW-1:0] out_product;

  antilog_shift_out #(.DWIDTH(DW), .M_WIDTH(MW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_final_k(in_final_k), .in_mantissa(in_mantissa), .in_zero(in_zero),
    .in_sign(in_sign), .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_sign(out_sign), .out_ovf(out_ovf),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] p;
    logic          s;
    logic          o;
  } exp_t;

  exp_t eq[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   sticky_m = 1'b0;
  bit   was_held = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Value is m * 2^k / 2^MW, floored; saturates once k reaches the top product bit.
  function automatic exp_t model(input logic [3:0] k, input logic [6:0] m,
                                 input logic z, input logic s);
    exp_t e;
    longint unsigned full;
    full = (longint'(m) * (64'd1 << k)) / 64'd64;
    if (z) begin
      e.p = '0; e.s = 1'b0; e.o = 1'b0;
    end else if (int'(k) + 1 >= PW) begin
      e.p = '1; e.s = s; e.o = 1'b1;
    end else begin
      e.p = full[PW-1:0]; e.s = s; e.o = 1'b0;
    end
    return e;
  endfunction

  task automatic cycle(input logic v, input logic [3:0] k, input logic [6:0] m,
                       input logic z, input logic s, input logic ordy, input logic clr,
                       output bit acc);
    exp_t    e;
    bit      xfer_ovf;
    logic [PW-1:0] mw;
    @(negedge clk);
    mw = PW'($urandom);
    mw[6:0] = m;
    in_valid = v; in_final_k = k; in_mantissa = mw; in_zero = z; in_sign = s;
    out_ready = ordy; ovf_clr = clr;
    #1;
    xfer_ovf = 1'b0;
    if (was_held) chk("held_valid", 32'(out_valid), 32'd1);
    if (out_valid) begin
      chk("out_expected", 32'(eq.size() != 0), 32'd1);
      if (eq.size() != 0) begin
        e = eq[0];
        chk("product", 32'(out_product), 32'(e.p));
        chk("sign", 32'(out_sign), 32'(e.s));
        chk("ovf", 32'(out_ovf), 32'(e.o));
        if (out_ready) begin
          xfer_ovf = e.o;
          void'(eq.pop_front());
        end
      end
    end
    was_held = out_valid && !out_ready;
    acc = in_valid && in_ready;
    if (acc) eq.push_back(model(k, m, z, s));
    @(posedge clk);
    #1;
    if (xfer_ovf) sticky_m = 1'b1;
    else if (clr) sticky_m = 1'b0;
    chk("sticky", 32'(ovf_sticky), 32'(sticky_m));
  endtask

  initial begin
    bit acc;
    int idx;
    int cyc;
    logic [3:0] wk[4];
    logic [6:0] wm[4];

    rst_n = 1'b0; in_valid = 0; in_final_k = 0; in_mantissa = 0; in_zero = 0;
    in_sign = 0; out_ready = 1; ovf_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_product", 32'(out_product), 32'd0);
    chk("rst_sign_ovf", 32'({out_sign, out_ovf}), 32'd0);
    chk("rst_sticky", 32'(ovf_sticky), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency: k=3, mantissa 1.100000 -> 12 after two cycles
    cycle(1, 4'd3, 7'b1100000, 0, 0, 1, 0, acc);
    chk("lat_accept", 32'(acc), 32'd1);
    chk("lat_cycle1", 32'(out_valid), 32'd0);
    cycle(0, 0, 0, 0, 0, 1, 0, acc);
    chk("lat_cycle2", 32'(out_valid), 32'd1);
    cycle(0, 0, 0, 0, 0, 1, 0, acc);

    // Back-to-back: 1024 signed, truncation to 1, zero-forced
    cycle(1, 4'd10, 7'b1000000, 0, 1, 1, 0, acc);
    chk("b2b_acc0", 32'(acc), 32'd1);
    cycle(1, 4'd0, 7'b1111111, 0, 0, 1, 0, acc);
    chk("b2b_acc1", 32'(acc), 32'd1);
    cycle(1, 4'd15, 7'b1111111, 1, 1, 1, 0, acc);
    chk("b2b_acc2", 32'(acc), 32'd1);
    repeat (3) cycle(0, 0, 0, 0, 0, 1, 0, acc);

    // Saturation, sticky clear, then set-wins-over-clear
    cycle(1, 4'd15, 7'b1111111, 0, 0, 1, 0, acc);
    repeat (2) cycle(0, 0, 0, 0, 0, 1, 0, acc);
    chk("sat_sticky_set", 32'(ovf_sticky), 32'd1);
    cycle(0, 0, 0, 0, 0, 1, 1, acc);
    chk("sat_sticky_clr", 32'(ovf_sticky), 32'd0);
    cycle(1, 4'd15, 7'b1000000, 0, 1, 1, 0, acc);
    cycle(0, 0, 0, 0, 0, 1, 0, acc);
    cycle(0, 0, 0, 0, 0, 1, 1, acc);
    chk("sticky_set_wins", 32'(ovf_sticky), 32'd1);
    cycle(0, 0, 0, 0, 0, 1, 1, acc);

    // Back-pressure: 4 words, out_ready low for 3 cycles after first out_valid
    for (int i = 0; i < 4; i++) begin
      wk[i] = 4'(4 + 2 * i);
      wm[i] = 7'(64 + 9 * i);
    end
    idx = 0;
    cyc = 0;
    while ((idx < 4 || eq.size() != 0) && cyc < 30) begin
      if (idx < 4) cycle(1, wk[idx], wm[idx], 0, 1'(idx), !(cyc >= 2 && cyc <= 4), 0, acc);
      else cycle(0, 0, 0, 0, 0, 1, 0, acc);
      if (cyc == 3) chk("bp_in_ready_low", 32'(acc), 32'd0);
      if (acc) idx++;
      cyc++;
    end
    chk("bp_all_delivered", 32'(idx * 16 + eq.size()), 32'd64);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic [6:0] m;
      m = 7'($urandom);
      if ($urandom_range(0, 3) != 0) m[6] = 1'b1;
      cycle(1'($urandom_range(0, 3) != 0), 4'($urandom), m,
            1'($urandom_range(0, 7) == 0), 1'($urandom),
            1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 15) == 0), acc);
    end
    cyc = 0;
    while (eq.size() != 0 && cyc < 10) begin
      cycle(0, 0, 0, 0, 0, 1, 0, acc);
      cyc++;
    end
    chk("rand_drained", 32'(eq.size()), 32'd0);

    // Reset with two words in flight
    cycle(1, 4'd7, 7'b1010101, 0, 0, 1, 0, acc);
    cycle(1, 4'd8, 7'b1100110, 0, 1, 1, 0, acc);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    eq.delete();
    was_held = 1'b0;
    sticky_m = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 4'd9, 7'b1000001, 0, 1, 1, 0, acc);
    chk("post_rst_out0", 32'(out_valid), 32'd0);
    cycle(0, 0, 0, 0, 0, 1, 0, acc);
    chk("post_rst_out1", 32'(out_valid), 32'd1);
    cycle(0, 0, 0, 0, 0, 1, 0, acc);
    chk("post_rst_alone", 32'(out_valid), 32'd0);
    chk("post_rst_drained", 32'(eq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
